div_unit: RTL and testbench

Iterative 64-bit integer divider for the RV64M DIV/DIVU/REM/REMU group. It sits in the execute stage beside the single-cycle `ALU` and takes the same `A`/`B` operands and `Func3` field that `ALU_Control` decodes. It is used whenever `Func7 = 7'b0000001` and `Func3[2] = 1`. Division takes many cycles, so the block uses a start/busy/done handshake. The pipeline stalls on `Busy` and captures `Result` on `Done`.

---
 rtl/div_unit_if.sv | 14 +
 rtl/div_unit.sv | 117 +++++++++++
 tb/tb_div_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Start/busy/done handshake bundle between the execute stage and the iterative divider.
interface div_unit_if #(parameter int XLEN = 64);
  logic            Start;
  logic [2:0]      Func3;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;
  logic            DivByZero;

  modport master (output Start, Func3, A, B, input Busy, Done, Result, DivByZero);
  modport slave  (input Start, Func3, A, B, output Busy, Done, Result, DivByZero);
endinterface

// File: rtl/div_unit.sv
// Iterative RV64M DIV/DIVU/REM/REMU unit: restoring radix-2, one quotient bit per cycle,
// with a two-cycle shortcut for divide-by-zero and signed overflow.
module div_unit #(
  parameter int XLEN = 64
) (
  input logic       Clk,
  input logic       Reset_n,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CALC, FIX, SPECIAL, DONE} state_t;

  state_t          state, next_state;
  logic            sel_rem;
  logic [XLEN-1:0] dvd;     // dividend bits shift out MSB-first, quotient bits shift in at LSB
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   rem;
  logic [CW-1:0]   cnt;
  logic            q_neg, r_neg;

  logic            accept, special, op_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN+1:0] shifted, diff;
  logic            q_bit;

  // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    accept    = (state == IDLE || state == DONE) && bus.Start && bus.Func3[2];
    op_signed = ~bus.Func3[0];
    special   = (bus.B == '0) || (op_signed && bus.A == MIN_INT && bus.B == '1);
    a_abs     = (op_signed && bus.A[XLEN-1]) ? -bus.A : bus.A;
    b_abs     = (op_signed && bus.B[XLEN-1]) ? -bus.B : bus.B;
    shifted   = {rem, dvd[XLEN-1]};
    diff      = shifted - {2'b00, b_mag};
    q_bit     = ~diff[XLEN+1];
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE:    next_state = accept ? (special ? SPECIAL : CALC) : IDLE;
      CALC:          if (cnt == '0) next_state = FIX;
      FIX, SPECIAL:  next_state = DONE;
      default:       next_state = IDLE;
    endcase
  end

  // Busy/Done are registered from the next state so they carry no input-to-output path.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
    end else begin
      state    <= next_state;
      bus.Busy <= (next_state == CALC) || (next_state == FIX) || (next_state == SPECIAL);
      bus.Done <= (next_state == DONE);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel_rem       <= 1'b0;
      dvd           <= '0;
      b_mag         <= '0;
      rem           <= '0;
      cnt           <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      bus.Result    <= '0;
      bus.DivByZero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            sel_rem       <= bus.Func3[1];
            bus.DivByZero <= (bus.B == '0);
            bus.Result    <= '0;
            rem           <= '0;
            cnt           <= CW'(XLEN - 1);
            if (special) begin
              dvd   <= bus.A;
              b_mag <= bus.B;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              dvd   <= a_abs;
              b_mag <= b_abs;
              q_neg <= op_signed & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
              r_neg <= op_signed & bus.A[XLEN-1];
            end
          end
        end
        CALC: begin
          rem <= q_bit ? diff[XLEN:0] : shifted[XLEN:0];
          dvd <= {dvd[XLEN-2:0], q_bit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (sel_rem) bus.Result <= r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
          else         bus.Result <= q_neg ? -dvd : dvd;
        end
        SPECIAL: begin
          // dvd still holds the raw dividend: it is the B==0 remainder and the overflow quotient.
          if (bus.DivByZero) bus.Result <= sel_rem ? dvd : '1;
          else               bus.Result <= sel_rem ? '0 : dvd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV64M cases, handshake/reset scenarios and
// random operands, with expected results queued at issue and popped on Done.
module tb_div_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] MIN_INT = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] res;
    logic        dbz;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  div_unit_if #(.XLEN(XLEN)) bus ();
  div_unit #(.XLEN(XLEN)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) return f[1] ? a : ONES;
    if (!f[0] && a == MIN_INT && b == ONES) return f[1] ? 64'd0 : a;
    case (f[1:0])
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Drives one Start pulse (accepted on the next rising edge) and queues its expected outcome.
  task automatic start_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input logic ed);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Func3 = f;
    bus.A     = a;
    bus.B     = b;
    exp_q.push_back('{res: er, dbz: ed});
    @(posedge Clk);
    #1 bus.Start = 1'b0;
  endtask

  // Samples #1 after each edge until Done; lat counts cycles since the Start cycle.
  task automatic wait_done(input int lat0, output int lat, output int busy_n);
    lat    = lat0;
    busy_n = 0;
    while (bus.Done !== 1'b1 && lat < 300) begin
      if (bus.Busy === 1'b1) busy_n++;
      @(posedge Clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset;
    bus.Start = 1'b0; bus.Func3 = 3'b000; bus.A = '0; bus.B = '0;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
    #1;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.Done); end
    n_cmp++; if (bus.Result !== 64'd0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.Result); end
    n_cmp++; if (bus.DivByZero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", bus.DivByZero); end
  endtask

  task automatic test_ignore_func;
    @(negedge Clk);
    bus.Start = 1'b1; bus.Func3 = 3'b000; bus.A = 64'd9; bus.B = 64'd3;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL ignore_func3_busy got %b want 0", bus.Busy); end
    @(posedge Clk); #1;
    n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL ignore_func3_done got %b want 0", bus.Done); end
  endtask

  task automatic test_divu_latency;
    int lat, bn;
    exp_t e;
    start_op(3'b101, 64'd40, 64'd5, 64'd8, 1'b0);
    wait_done(1, lat, bn);
    e = exp_q.pop_front();
    n_cmp++; if (bus.Result !== e.res) begin n_err++; $display("FAIL divu_result got %h want %h", bus.Result, e.res); end
    n_cmp++; if (lat != 66) begin n_err++; $display("FAIL divu_latency got %0d want 66", lat); end
    n_cmp++; if (bn != 65) begin n_err++; $display("FAIL divu_busy_cycles got %0d want 65", bn); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL divu_busy_at_done got %b want 0", bus.Busy); end
    @(posedge Clk); #1;
    n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL divu_done_pulse got %b want 0", bus.Done); end
    n_cmp++; if (bus.Result !== 64'd8) begin n_err++; $display("FAIL divu_result_hold got %h want 8", bus.Result); end
  endtask

  task automatic test_signed;
    logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b111, 3'b101};
    logic [63:0] as [4] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, ONES, ONES};
    logic [63:0] es [4] = '{64'hFFFF_FFFF_FFFF_FFFD, ONES, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF};
    int lat, bn;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      start_op(fs[i], as[i], 64'd2, es[i], 1'b0);
      wait_done(1, lat, bn);
      e = exp_q.pop_front();
      n_cmp++; if (bus.Result !== e.res) begin n_err++; $display("FAIL signed_case%0d got %h want %h", i, bus.Result, e.res); end
      n_cmp++; if (lat != 66) begin n_err++; $display("FAIL signed_latency%0d got %0d want 66", i, lat); end
    end
  endtask

  task automatic test_special;
    logic [2:0]  fs [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [63:0] as [4] = '{64'd123, 64'd123, MIN_INT, MIN_INT};
    logic [63:0] bs [4] = '{64'd0, 64'd0, ONES, ONES};
    logic [63:0] es [4] = '{ONES, 64'd123, MIN_INT, 64'd0};
    logic        ds [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat, bn;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      start_op(fs[i], as[i], bs[i], es[i], ds[i]);
      wait_done(1, lat, bn);
      e = exp_q.pop_front();
      n_cmp++; if (bus.Result !== e.res) begin n_err++; $display("FAIL special_result%0d got %h want %h", i, bus.Result, e.res); end
      n_cmp++; if (bus.DivByZero !== e.dbz) begin n_err++; $display("FAIL special_dbz%0d got %b want %b", i, bus.DivByZero, e.dbz); end
      n_cmp++; if (lat != 2) begin n_err++; $display("FAIL special_latency%0d got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_busy_ignore;
    int lat, bn;
    exp_t e;
    start_op(3'b101, 64'd1000, 64'd3, 64'd333, 1'b0);
    repeat (9) begin @(posedge Clk); #1; end
    @(negedge Clk);
    bus.Start = 1'b1; bus.Func3 = 3'b100; bus.A = 64'd7; bus.B = 64'd0;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    wait_done(11, lat, bn);
    e = exp_q.pop_front();
    n_cmp++; if (bus.Result !== e.res) begin n_err++; $display("FAIL busy_ignore_result got %h want %h", bus.Result, e.res); end
    n_cmp++; if (bus.DivByZero !== 1'b0) begin n_err++; $display("FAIL busy_ignore_dbz got %b want 0", bus.DivByZero); end
    n_cmp++; if (lat != 66) begin n_err++; $display("FAIL busy_ignore_latency got %0d want 66", lat); end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    exp_t e;
    start_op(3'b101, 64'd40, 64'd5, 64'd8, 1'b0);
    wait_done(1, lat, bn);
    e = exp_q.pop_front();
    n_cmp++; if (bus.Result !== e.res) begin n_err++; $display("FAIL b2b_first got %h want %h", bus.Result, e.res); end
    start_op(3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);
    n_cmp++; if (bus.Result !== 64'd0) begin n_err++; $display("FAIL b2b_result_cleared got %h want 0", bus.Result); end
    n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", bus.Busy); end
    wait_done(1, lat, bn);
    e = exp_q.pop_front();
    n_cmp++; if (bus.Result !== e.res) begin n_err++; $display("FAIL b2b_second got %h want %h", bus.Result, e.res); end
    n_cmp++; if (lat != 66) begin n_err++; $display("FAIL b2b_latency got %0d want 66", lat); end
  endtask

  task automatic test_reset_mid_calc;
    int dones = 0;
    start_op(3'b111, 64'd12345, 64'd0, 64'd12345, 1'b1);
    @(posedge Clk); #1;
    n_cmp++; if (bus.DivByZero !== 1'b1) begin n_err++; $display("FAIL pre_reset_dbz got %b want 1", bus.DivByZero); end
    void'(exp_q.pop_front());
    start_op(3'b101, ONES, 64'd13, ONES / 64'd13, 1'b0);
    repeat (20) begin @(posedge Clk); #1; end
    @(negedge Clk) Reset_n = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got %b want 0", bus.Busy); end
    n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL midreset_done got %b want 0", bus.Done); end
    n_cmp++; if (bus.Result !== 64'd0) begin n_err++; $display("FAIL midreset_result got %h want 0", bus.Result); end
    n_cmp++; if (bus.DivByZero !== 1'b0) begin n_err++; $display("FAIL midreset_dbz got %b want 0", bus.DivByZero); end
    @(negedge Clk) Reset_n = 1'b1;
    repeat (80) begin
      @(posedge Clk); #1;
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) dones++;
    end
    n_cmp++; if (dones != 0) begin n_err++; $display("FAIL midreset_no_done got %0d active cycles want 0", dones); end
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [63:0] a, b;
    logic        spec;
    int lat, bn;
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      f = 3'b100 | 3'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) a = MIN_INT;
      case ($urandom_range(0, 9))
        0:       b = 64'd0;
        1:       b = ONES;
        2, 3:    b = 64'($urandom_range(1, 100));
        4:       b = -64'($urandom_range(1, 100));
        default: b = {$urandom, $urandom};
      endcase
      spec = (b == 64'd0) || (!f[0] && a == MIN_INT && b == ONES);
      start_op(f, a, b, model(f, a, b), b == 64'd0);
      wait_done(1, lat, bn);
      e = exp_q.pop_front();
      n_cmp++; if (bus.Result !== e.res || bus.DivByZero !== e.dbz) begin
        n_err++; $display("FAIL random%0d f=%b a=%h b=%h got %h/%b want %h/%b", i, f, a, b, bus.Result, bus.DivByZero, e.res, e.dbz);
      end
      n_cmp++; if (lat != (spec ? 2 : 66)) begin n_err++; $display("FAIL random_latency%0d got %0d want %0d", i, lat, spec ? 2 : 66); end
    end
  endtask

  initial begin
    test_reset();
    test_ignore_func();
    test_divu_latency();
    test_signed();
    test_special();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
